// File: rtl/mem_access_unit.sv
// Memory access unit: turns multicycle-controller strobes into a req/ack memory handshake and owns IR/MDR.
// Optional build macro MEM_TIMEOUT_EN adds a BUSY watchdog that aborts a stuck access and raises sticky err.
module mem_access_unit #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic [DATA_W-1:0] ir_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic [3:0]        opcode,
    output logic [3:0]        func_field,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t state;
    state_t state_next;
    op_t    op_q;
    op_t    op_sel;

    logic              any_strobe;
    logic              start;
    logic              ack_hit;
    logic              timeout_hit;
    logic              finish;
    logic [DATA_W-1:0] load_val;

    assign any_strobe = ir_write | mem_read | mem_write;
    assign start      = (state == IDLE) & any_strobe;
    assign ack_hit    = (state == BUSY) & mem_ack;
    assign finish     = ack_hit | timeout_hit;

    // A timed-out access loads zero so a dead fetch decodes to the controller's default path.
    assign load_val   = ack_hit ? mem_rdata : '0;

    assign stall      = (state == BUSY) | start;
    assign opcode     = ir_q[15:12];
    assign func_field = ir_q[3:0];

    // Simultaneous strobes are a controller bug; the lower-priority ops are silently dropped.
    always_comb begin
        op_sel = OP_READ;
        if (ir_write) begin
            op_sel = OP_FETCH;
        end else if (mem_write) begin
            op_sel = OP_WRITE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE is a one-cycle guard so a strobe still held by the controller cannot retrigger.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_strobe) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_FETCH;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
        end else begin
            if (start) begin
                op_q      <= op_sel;
                mem_req   <= 1'b1;
                mem_we    <= (op_sel == OP_WRITE);
                mem_addr  <= (op_sel == OP_FETCH) ? pc_addr : alu_addr;
                mem_wdata <= wr_data;
            end else if (finish) begin
                mem_req <= 1'b0;
                if (op_q == OP_FETCH) begin
                    ir_q <= load_val;
                end
                if (op_q == OP_READ) begin
                    mdr_q <= load_val;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        err_q;

    // The count equals the number of ack-less BUSY cycles already spent on this request.
    assign timeout_hit = (state == BUSY) & ~mem_ack & (tmo_cnt == TMO_LAST);
    assign err         = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                tmo_cnt <= '0;
            end else if ((state == BUSY) & ~mem_ack) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model of outputs compared every cycle, plus literal pins.
// Build with MEM_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_mem_access_unit;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ir_write = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] pc_addr = '0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          stall;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] mdr_q;
  logic [3:0]    opcode;
  logic [3:0]    func_field;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ir_write(ir_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .pc_addr(pc_addr),
    .alu_addr(alu_addr),
    .wr_data(wr_data),
    .stall(stall),
    .ir_q(ir_q),
    .mdr_q(mdr_q),
    .opcode(opcode),
    .func_field(func_field),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .err(err)
  );

  // ---------------- scoreboard / model state ----------------
  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] exp_ir    = '0;
  logic [DW-1:0] exp_mdr   = '0;
  logic          exp_err   = 1'b0;
  logic          exp_stall = 1'b0;
  logic          exp_req   = 1'b0;
  logic [32:0]   exp_q[$];
  logic [32:0]   cur = '0;

  bit chk_en     = 1'b0;
  bit req_prev   = 1'b0;
  bit stall_prev = 1'b0;
  int req_len    = 0;
  int last_req_len   = 0;
  int stall_len      = 0;
  int last_stall_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One compare process: every cycle, DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("ir_q", 32'(ir_q), 32'(exp_ir));
      chk("mdr_q", 32'(mdr_q), 32'(exp_mdr));
      chk("opcode", 32'(opcode), 32'(exp_ir[15:12]));
      chk("func_field", 32'(func_field), 32'(exp_ir[3:0]));
      chk("err", 32'(err), 32'(exp_err));
      if (mem_req && !req_prev) begin
        req_len = 0;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_req: got request expected none at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (mem_req) begin
        req_len++;
        chk("mem_we", 32'(mem_we), 32'(cur[32]));
        chk("mem_addr", 32'(mem_addr), 32'(cur[31:16]));
        chk("mem_wdata", 32'(mem_wdata), 32'(cur[15:0]));
      end else if (req_prev) begin
        last_req_len = req_len;
      end
      if (stall && !stall_prev) stall_len = 0;
      if (stall) stall_len++;
      else if (stall_prev) last_stall_len = stall_len;
      req_prev   = mem_req;
      stall_prev = stall;
    end
  end

  // ---------------- driver tasks ----------------
  // strb = {ir_write, mem_write, mem_read}; ack arrives in request cycle n (or never if ack_it = 0).
  task automatic do_access(input logic [2:0] strb, input logic [15:0] pc, input logic [15:0] alu,
                           input logic [15:0] wd, input logic [15:0] rd, input int n, input bit ack_it);
    bit is_fetch, is_write, is_read;
    is_fetch = strb[2];
    is_write = !strb[2] && strb[1];
    is_read  = !strb[2] && !strb[1] && strb[0];
    ir_write  = strb[2];
    mem_write = strb[1];
    mem_read  = strb[0];
    pc_addr   = pc;
    alu_addr  = alu;
    wr_data   = wd;
    exp_q.push_back({is_write, (is_fetch ? pc : alu), wd});
    exp_stall = 1'b1;
    exp_req   = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= n; k++) begin
      exp_req   = 1'b1;
      exp_stall = 1'b1;
      pc_addr   = 16'($urandom_range(0, 65535));
      alu_addr  = 16'($urandom_range(0, 65535));
      wr_data   = 16'($urandom_range(0, 65535));
      mem_ack   = ack_it && (k == n);
      mem_rdata = (ack_it && (k == n)) ? rd : 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
    end
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom_range(0, 65535));
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    if (ack_it) begin
      if (is_fetch) exp_ir = rd;
      if (is_read) exp_mdr = rd;
    end else begin
      exp_err = 1'b1;
      if (is_fetch) exp_ir = '0;
      if (is_read) exp_mdr = '0;
    end
    @(posedge clk); #1;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic spurious_ack(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #17 rst = 1'b0;
    #1;
    chk("rst_ir_q", 32'(ir_q), 32'h0);
    chk("rst_mdr_q", 32'(mdr_q), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // Reset in the middle of an outstanding fetch.
    @(posedge clk); #1;
    ir_write = 1'b1;
    pc_addr  = 16'h0055;
    @(posedge clk); #1;
    chk("busy_mem_req", 32'(mem_req), 32'h1);
    chk("busy_mem_addr", 32'(mem_addr), 32'h0055);
    @(posedge clk); #1;
    rst      = 1'b1;
    ir_write = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'h0);
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("lateack_ir_q", 32'(ir_q), 32'h0);
    chk("lateack_stall", 32'(stall), 32'h0);
    chk("lateack_mem_req", 32'(mem_req), 32'h0);

    chk_en = 1'b1;
    @(posedge clk); #1;

    // Zero-wait fetch.
    do_access(3'b100, 16'h0010, 16'h7777, 16'h0000, 16'h8123, 1, 1'b1);
    chk("fetch_ir_q", 32'(ir_q), 32'h8123);
    chk("fetch_opcode", 32'(opcode), 32'h8);
    chk("fetch_func", 32'(func_field), 32'h3);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h0010);
    chk("fetch_mem_we", 32'(mem_we), 32'h0);
    chk("fetch_req_len", 32'(last_req_len), 32'd1);
    chk("fetch_stall_len", 32'(last_stall_len), 32'd2);

    // Wait-state load: ack in the 4th request cycle.
    do_access(3'b001, 16'h1111, 16'h00A0, 16'h0000, 16'hBEEF, 4, 1'b1);
    chk("load_mdr_q", 32'(mdr_q), 32'hBEEF);
    chk("load_ir_q", 32'(ir_q), 32'h8123);
    chk("load_req_len", 32'(last_req_len), 32'd4);
    chk("load_stall_len", 32'(last_stall_len), 32'd5);

    // Store.
    do_access(3'b010, 16'h2222, 16'h0042, 16'h1234, 16'h5A5A, 3, 1'b1);
    chk("store_mem_we", 32'(mem_we), 32'h1);
    chk("store_mem_addr", 32'(mem_addr), 32'h0042);
    chk("store_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("store_ir_q", 32'(ir_q), 32'h8123);
    chk("store_mdr_q", 32'(mdr_q), 32'hBEEF);

    // Ack while idle changes nothing.
    spurious_ack(2);
    chk("spur_ir_q", 32'(ir_q), 32'h8123);
    chk("spur_mdr_q", 32'(mdr_q), 32'hBEEF);

    // Simultaneous strobes: fetch beats read, write beats read.
    do_access(3'b101, 16'h0200, 16'h0300, 16'h0000, 16'h4567, 2, 1'b1);
    chk("multi_ir_q", 32'(ir_q), 32'h4567);
    chk("multi_mem_addr", 32'(mem_addr), 32'h0200);
    chk("multi_mdr_q", 32'(mdr_q), 32'hBEEF);
    do_access(3'b011, 16'h0500, 16'h0400, 16'hAAAA, 16'h3333, 1, 1'b1);
    chk("multi2_mem_we", 32'(mem_we), 32'h1);
    chk("multi2_mem_addr", 32'(mem_addr), 32'h0400);
    chk("multi2_mdr_q", 32'(mdr_q), 32'hBEEF);

    do_access(3'b001, 16'h0000, 16'h0ABC, 16'h5555, 16'h1357, 6, 1'b1);
    chk("long_mdr_q", 32'(mdr_q), 32'h1357);

`ifdef MEM_TIMEOUT_EN
    // Ack coincident with the last allowed cycle wins over the timeout.
    do_access(3'b001, 16'h0000, 16'h0C00, 16'h0000, 16'h2468, TMO, 1'b1);
    chk("edgeack_mdr_q", 32'(mdr_q), 32'h2468);
    chk("edgeack_err", 32'(err), 32'h0);
    do_access(3'b100, 16'h0D00, 16'h0000, 16'h0000, 16'h0000, TMO, 1'b0);
    chk("tmo_ir_q", 32'(ir_q), 32'h0);
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_req_len", 32'(last_req_len), 32'd8);
    do_access(3'b001, 16'h0000, 16'h0E00, 16'h0000, 16'h9999, 2, 1'b1);
    chk("after_tmo_mdr_q", 32'(mdr_q), 32'h9999);
    chk("after_tmo_err", 32'(err), 32'h1);
`else
    chk("no_tmo_err", 32'(err), 32'h0);
`endif

    @(posedge clk); #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle control FSM, between the controller/datapath and a single-ported 16-bit word-addressed memory.
- Converts the controller's level strobes (IRWrite, MemRead, MemWrite) into a req/ack handshake to a variable-latency memory.
- Holds the instruction register (IR) and memory data register (MDR). Feeds opcode and func_field back to the controller.
- Asserts stall while an access is outstanding, so the controller's state register holds.

Parameters:
- DATA_W, 16, memory word and IR/MDR width.
- ADDR_W, 16, memory address width.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without ack before abort; only used with MEM_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir_write  in  1  controller strobe: fetch instruction at pc_addr.
- mem_read  in  1  controller strobe: load word at alu_addr.
- mem_write  in  1  controller strobe: store wr_data at alu_addr.
- pc_addr  in  ADDR_W  fetch address (PC).
- alu_addr  in  ADDR_W  data address (ALUOut).
- wr_data  in  DATA_W  store data (B register).
- stall  out  1  controller must hold state while high.
- ir_q  out  DATA_W  instruction register.
- mdr_q  out  DATA_W  memory data register.
- opcode  out  4  ir_q[15:12].
- func_field  out  4  ir_q[3:0].
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  registered access address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ack  in  1  memory completion, sampled only while mem_req = 1.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
- err  out  1  sticky access-timeout flag.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, ir_q, mdr_q, err, timeout counter all = 0.
  - A reset mid-access drops mem_req at once; any late mem_ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any strobe is high, latch the op by priority ir_write > mem_write > mem_read.
  - Latch mem_addr: pc_addr for a fetch, otherwise alu_addr.
  - Latch mem_wdata = wr_data; set mem_we = 1 for a write only.
  - Go to BUSY.
  - With no strobe, stay in IDLE; all memory outputs hold their values and mem_req = 0.
- BUSY:
  - mem_req = 1. mem_addr, mem_we and mem_wdata are stable for the whole request.
  - On a cycle with mem_ack = 1: fetch loads ir_q <= mem_rdata; read loads mdr_q <= mem_rdata; write captures nothing.
  - On that same ack edge, mem_req drops to 0 and the FSM goes to DONE.
- DONE:
  - Lasts one cycle; strobes are ignored.
  - Go to IDLE. This prevents the still-asserted strobe from retriggering before the controller advances.
- stall (combinational):
  - stall = (state == BUSY) | (state == IDLE & (ir_write | mem_read | mem_write)).
  - stall is 0 in DONE.
- Minimum access latency, ack in the first BUSY cycle:
  - Strobe seen in cycle 0 (IDLE).
  - mem_req high in cycle 1; ack in cycle 1.
  - DONE in cycle 2, where the controller advances; IDLE in cycle 3.
  - New ir_q/mdr_q is visible from cycle 2.
- Output stability:
  - ir_q changes only on a fetch ack, so opcode/func_field are stable through decode and execute.
  - mdr_q changes only on a read ack.
- mem_ack while mem_req = 0 (IDLE/DONE): ignored, no state change.
- Multiple strobes in one IDLE cycle: only the highest-priority op is performed; the others are dropped.
  - This is a controller bug and is not flagged.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: mem_req drops, err is set (sticky until rst), and the FSM goes to DONE.
  - On a timed-out fetch, ir_q is loaded with 16'h0000 (decodes to the controller's default path back to fetch).
  - On a timed-out read, mdr_q is loaded with 16'h0000. A timed-out write has no side effect.
  - An ack arriving in the same cycle as the timeout takes priority: normal completion, err not set.
- MEM_TIMEOUT_EN not defined:
  - BUSY waits indefinitely for ack.
  - err is tied to 0 and the counter is not synthesized.

Test Plan:
- Reset during BUSY: assert rst while mem_req = 1 -> mem_req = 0 immediately, state IDLE; an ack pulse after release leaves ir_q = 0 and stall = 0.
- Zero-wait fetch: pc_addr = 16'h0010, ir_write = 1, memory acks in the first req cycle with mem_rdata = 16'h8123 -> mem_req high 1 cycle, mem_addr = 16'h0010, mem_we = 0, ir_q = 16'h8123, opcode = 4'h8, func_field = 4'h3, stall low in the DONE cycle.
- Wait-state load: mem_read = 1, alu_addr = 16'h00A0, ack after 4 cycles with rdata = 16'hBEEF -> mem_req high exactly 4 cycles, stall high 5 cycles, mdr_q = 16'hBEEF, ir_q unchanged.
- Store: mem_write = 1, alu_addr = 16'h0042, wr_data = 16'h1234 -> mem_we = 1, mem_addr = 16'h0042, mem_wdata = 16'h1234 held stable until ack; ir_q and mdr_q unchanged.
- Held strobe, no retrigger: ir_write held high across DONE -> exactly one request issued; a spurious ack while idle changes nothing.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8: fetch with ack never asserted -> mem_req drops after 8 cycles, err = 1, ir_q = 16'h0000; the next access with an ack completes normally and err stays 1.
